// File: rtl/sa_stream_feeder.sv
// sa_stream_feeder: stages X/Q/K/V bytes, streams one task into SA, then collects its result burst.
// Define SA_FEED_CHKSUM_EN to add an XOR checksum port over the received results.
module sa_stream_feeder #(
    parameter int DW      = 8,
    parameter int OW      = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [5:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [3:0]    cfg_T,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          err,
    output logic          sa_in_valid,
    output logic [3:0]    sa_T,
    output logic [DW-1:0] sa_in_data,
    output logic [DW-1:0] sa_w_Q,
    output logic [DW-1:0] sa_w_K,
    output logic [DW-1:0] sa_w_V,
    input  logic          sa_out_valid,
    input  logic [OW-1:0] sa_out_data,
    output logic [6:0]    rx_count
`ifdef SA_FEED_CHKSUM_EN
    ,
    output logic [OW-1:0] chksum
`endif
);
    typedef enum logic [2:0] {IDLE, FEED, WAIT, RECV, DONE} state_t;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 2);

    state_t state_q, state_d;
    logic [DW-1:0] mem_q [256];
    logic [DW-1:0] mem_d [256];
    logic [7:0] beat_q, beat_d;
    logic [3:0] t_q, t_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [6:0] rx_q, rx_d;
    logic err_q, err_d, to_q, to_d;
    logic in_valid_q, in_valid_d;
    logic [3:0] sa_t_q, sa_t_d;
    logic [DW-1:0] x_q, x_d, wq_q, wq_d, wk_q, wk_d, wv_q, wv_d;
    logic t_ok, go, emit, cnt;
    logic [7:0] b;
    logic [3:0] t;
`ifdef SA_FEED_CHKSUM_EN
    logic [OW-1:0] chk_q, chk_d;
`else
    logic unused_data;
    assign unused_data = ^sa_out_data;
`endif

    // Stream reads use mem_d so a host write in the start cycle reaches beat 0.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && state_q == IDLE) mem_d[{wr_sel, wr_addr}] = wr_data;
        t_ok = cfg_T == 4'd1 || cfg_T == 4'd4 || cfg_T == 4'd8;
        go = state_q == IDLE && start && t_ok;
        emit = go || (state_q == FEED && beat_q != 8'd192);
        b = go ? 8'd0 : beat_q;
        t = go ? cfg_T : t_q;
        cnt = sa_out_valid && (state_q == WAIT || state_q == RECV);
        beat_d = emit ? b + 8'd1 : 8'd0;
        t_d = t;
        wait_d = state_q == WAIT ? wait_q + WW'(1) : '0;
        rx_d = go ? 7'd0 : rx_q + {6'd0, cnt};
        to_d = go ? 1'b0 : to_q;
        err_d = (state_q == IDLE && start && !t_ok) || (state_q != IDLE && (wr_en || start));
        in_valid_d = emit;
        sa_t_d = (emit && b == 8'd0) ? t : 4'd0;
        x_d = (emit && b < {1'b0, t, 3'b000}) ? mem_d[{2'b00, b[5:0]}] : '0;
        wq_d = (emit && b[7:6] == 2'd0) ? mem_d[{2'b01, b[5:0]}] : '0;
        wk_d = (emit && b[7:6] == 2'd1) ? mem_d[{2'b10, b[5:0]}] : '0;
        wv_d = (emit && b[7:6] == 2'd2) ? mem_d[{2'b11, b[5:0]}] : '0;
`ifdef SA_FEED_CHKSUM_EN
        chk_d = go ? '0 : cnt ? chk_q ^ sa_out_data : chk_q;
`endif
        state_d = state_q;
        case (state_q)
            IDLE: state_d = go ? FEED : IDLE;
            FEED: state_d = beat_q == 8'd192 ? WAIT : FEED;
            WAIT: begin
                if (sa_out_valid) begin
                    state_d = RECV;
                end else if (wait_q == WLIM) begin
                    state_d = DONE;
                    to_d = 1'b1;
                end
            end
            RECV: state_d = (cnt && rx_d == {t_q, 3'b000}) ? DONE : RECV;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q <= '0;
            t_q <= '0;
            wait_q <= '0;
            rx_q <= '0;
            err_q <= 1'b0;
            to_q <= 1'b0;
            in_valid_q <= 1'b0;
            sa_t_q <= '0;
            x_q <= '0;
            wq_q <= '0;
            wk_q <= '0;
            wv_q <= '0;
`ifdef SA_FEED_CHKSUM_EN
            chk_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            t_q <= t_d;
            wait_q <= wait_d;
            rx_q <= rx_d;
            err_q <= err_d;
            to_q <= to_d;
            in_valid_q <= in_valid_d;
            sa_t_q <= sa_t_d;
            x_q <= x_d;
            wq_q <= wq_d;
            wk_q <= wk_d;
            wv_q <= wv_d;
`ifdef SA_FEED_CHKSUM_EN
            chk_q <= chk_d;
`endif
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign timeout = done && to_q;
    assign err = err_q;
    assign rx_count = rx_q;
    assign sa_in_valid = in_valid_q;
    assign sa_T = sa_t_q;
    assign sa_in_data = x_q;
    assign sa_w_Q = wq_q;
    assign sa_w_K = wk_q;
    assign sa_w_V = wv_q;
`ifdef SA_FEED_CHKSUM_EN
    assign chksum = chk_q;
`endif
endmodule

// File: tb/tb_sa_stream_feeder.sv
// tb_sa_stream_feeder: directed tests of the SA stream feeder against hand-derived values.
module tb_sa_stream_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en = 1'b0;
    logic [1:0] wr_sel = '0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic start = 1'b0;
    logic [3:0] cfg_T = '0;
    logic busy, done, timeout, err, sa_in_valid;
    logic [3:0] sa_T;
    logic [7:0] sa_in_data, sa_w_Q, sa_w_K, sa_w_V;
    logic sa_out_valid = 1'b0;
    logic [63:0] sa_out_data = '0;
    logic [6:0] rx_count;
`ifdef SA_FEED_CHKSUM_EN
    logic [63:0] chksum;
`endif
    int tests = 0;
    int fails = 0;
    logic [7:0] ex [64];
    logic [7:0] eq [64];
    logic [7:0] ek [64];
    logic [7:0] ev [64];
    logic [7:0] cap_x [192];
    logic [7:0] cap_q [192];
    logic [7:0] cap_k [192];
    logic [7:0] cap_v [192];
    logic [3:0] cap_t [192];
    logic cap_vld [192];
    logic cap_err [192];

    sa_stream_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .cfg_T(cfg_T), .busy(busy), .done(done), .timeout(timeout), .err(err),
        .sa_in_valid(sa_in_valid), .sa_T(sa_T), .sa_in_data(sa_in_data), .sa_w_Q(sa_w_Q),
        .sa_w_K(sa_w_K), .sa_w_V(sa_w_V), .sa_out_valid(sa_out_valid), .sa_out_data(sa_out_data),
        .rx_count(rx_count)
`ifdef SA_FEED_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired: got no finish want finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] s, input logic [5:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        case (s)
            2'd0: ex[a] = d;
            2'd1: eq[a] = d;
            2'd2: ek[a] = d;
            default: ev[a] = d;
        endcase
    endtask

    task automatic run_feed(input logic [3:0] t, input bit wr0, input bit inj, input bit ov);
        start = 1'b1; cfg_T = t;
        if (wr0) begin
            wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 6'd0; wr_data = 8'h5A; ex[0] = 8'h5A;
        end
        step();
        start = 1'b0; wr_en = 1'b0;
        for (int b = 0; b < 192; b++) begin
            cap_vld[b] = sa_in_valid; cap_t[b] = sa_T; cap_x[b] = sa_in_data;
            cap_q[b] = sa_w_Q; cap_k[b] = sa_w_K; cap_v[b] = sa_w_V; cap_err[b] = err;
            sa_out_valid = ov;
            if (inj && b == 50) begin
                wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 6'd60; wr_data = 8'hEE; start = 1'b1; cfg_T = 4'd1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            step();
        end
        sa_out_valid = 1'b0; wr_en = 1'b0; start = 1'b0;
    endtask

    function automatic int count_bad(input logic [3:0] t);
        int n = 0;
        for (int b = 0; b < 192; b++) begin
            logic [7:0] x, q, k, v;
            logic [3:0] tt;
            x = (b < t * 8) ? ex[b % 64] : 8'd0;
            q = (b < 64) ? eq[b % 64] : 8'd0;
            k = (b >= 64 && b < 128) ? ek[b % 64] : 8'd0;
            v = (b >= 128) ? ev[b % 64] : 8'd0;
            tt = (b == 0) ? t : 4'd0;
            if (cap_x[b] !== x || cap_q[b] !== q || cap_k[b] !== k || cap_v[b] !== v || cap_t[b] !== tt || cap_vld[b] !== 1'b1) n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        tests++; if ({busy, done, timeout, err, sa_in_valid} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b want 00000", {busy, done, timeout, err, sa_in_valid}); end
        tests++; if ({sa_T, sa_in_data, sa_w_Q, sa_w_K, sa_w_V} !== 36'd0) begin fails++; $display("FAIL reset_bus got %h want 0", {sa_T, sa_in_data, sa_w_Q, sa_w_K, sa_w_V}); end
        tests++; if (rx_count !== 7'd0) begin fails++; $display("FAIL reset_rx got %0d want 0", rx_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_t1();
        int bad;
        for (int i = 0; i < 256; i++) wr(2'(i / 64), 6'(i % 64), 8'd1);
        run_feed(4'd1, 1'b1, 1'b0, 1'b0);
        bad = count_bad(4'd1);
        tests++; if (bad !== 0) begin fails++; $display("FAIL t1_stream bad beats got %0d want 0", bad); end
        tests++; if (cap_t[0] !== 4'd1) begin fails++; $display("FAIL t1_sa_T got %0d want 1", cap_t[0]); end
        tests++; if (cap_x[0] !== 8'h5A) begin fails++; $display("FAIL t1_start_write got %h want 5a", cap_x[0]); end
        tests++; if (cap_x[7] !== 8'd1 || cap_x[8] !== 8'd0) begin fails++; $display("FAIL t1_x_edge got %h/%h want 01/00", cap_x[7], cap_x[8]); end
        tests++; if (sa_in_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL t1_wait got valid=%b busy=%b want 0/1", sa_in_valid, busy); end
        for (int i = 0; i < 8; i++) begin
            sa_out_valid = 1'b1; sa_out_data = 64'(i + 1);
            step();
        end
        sa_out_valid = 1'b0;
        tests++; if (done !== 1'b1 || timeout !== 1'b0 || rx_count !== 7'd8) begin fails++; $display("FAIL t1_done got done=%b to=%b rx=%0d want 1/0/8", done, timeout, rx_count); end
        step();
        tests++; if (done !== 1'b0 || busy !== 1'b0 || rx_count !== 7'd8) begin fails++; $display("FAIL t1_after got done=%b busy=%b rx=%0d want 0/0/8", done, busy, rx_count); end
    endtask

    task automatic test_illegal();
        start = 1'b1; cfg_T = 4'd3;
        step();
        start = 1'b0;
        tests++; if (err !== 1'b1 || busy !== 1'b0 || sa_in_valid !== 1'b0) begin fails++; $display("FAIL illegal_err got err=%b busy=%b valid=%b want 1/0/0", err, busy, sa_in_valid); end
        step();
        tests++; if (err !== 1'b0 || sa_in_valid !== 1'b0 || rx_count !== 7'd8) begin fails++; $display("FAIL illegal_after got err=%b valid=%b rx=%0d want 0/0/8", err, sa_in_valid, rx_count); end
    endtask

    task automatic test_t8();
        int bad, sent, i;
        for (int n = 0; n < 64; n++) begin
            wr(2'd0, 6'(n), 8'(n + 16));
            wr(2'd1, 6'(n), 8'(n));
            wr(2'd2, 6'(n), 8'(-n));
            wr(2'd3, 6'(n), 8'(n) ^ 8'h55);
        end
        run_feed(4'd8, 1'b0, 1'b1, 1'b0);
        bad = count_bad(4'd8);
        tests++; if (bad !== 0) begin fails++; $display("FAIL t8_stream bad beats got %0d want 0", bad); end
        tests++; if (cap_t[0] !== 4'd8) begin fails++; $display("FAIL t8_sa_T got %0d want 8", cap_t[0]); end
        tests++; if (cap_k[64] !== 8'h00 || cap_k[127] !== 8'hC1) begin fails++; $display("FAIL t8_wk got %h/%h want 00/c1", cap_k[64], cap_k[127]); end
        tests++; if (cap_v[191] !== 8'h6A) begin fails++; $display("FAIL t8_wv191 got %h want 6a", cap_v[191]); end
        tests++; if (cap_err[50] !== 1'b0 || cap_err[51] !== 1'b1 || cap_err[52] !== 1'b0) begin fails++; $display("FAIL t8_busy_err got %b%b%b want 010", cap_err[50], cap_err[51], cap_err[52]); end
        tests++; if (cap_x[60] !== 8'h4C) begin fails++; $display("FAIL t8_dropped_write got %h want 4c", cap_x[60]); end
        sent = 0; i = 0;
        while (sent < 64 && i < 200) begin
            sa_out_valid = (i % 5) != 4;
            sa_out_data = 64'(i);
            step();
            if (i % 5 != 4) sent++;
            i++;
        end
        sa_out_valid = 1'b0;
        tests++; if (done !== 1'b1 || timeout !== 1'b0 || rx_count !== 7'd64) begin fails++; $display("FAIL t8_done got done=%b to=%b rx=%0d want 1/0/64", done, timeout, rx_count); end
        step();
    endtask

    task automatic test_timeout();
        int n, bad;
        run_feed(4'd4, 1'b0, 1'b0, 1'b1);
        bad = count_bad(4'd4);
        tests++; if (bad !== 0) begin fails++; $display("FAIL to_stream bad beats got %0d want 0", bad); end
        n = 1;
        while (done !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        tests++; if (n !== 1023) begin fails++; $display("FAIL to_delay got %0d want 1023", n); end
        tests++; if (timeout !== 1'b1 || rx_count !== 7'd0 || busy !== 1'b1) begin fails++; $display("FAIL to_flags got to=%b rx=%0d busy=%b want 1/0/1", timeout, rx_count, busy); end
        step();
        tests++; if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL to_after got %b%b%b want 000", done, timeout, busy); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; cfg_T = 4'd8;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        tests++; if (sa_in_valid !== 1'b1 || sa_w_K !== ek[36]) begin fails++; $display("FAIL mid_beat100 got valid=%b wk=%h want 1/%h", sa_in_valid, sa_w_K, ek[36]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if ({sa_in_valid, sa_T, sa_in_data, sa_w_Q, sa_w_K, sa_w_V, busy} !== 38'd0) begin fails++; $display("FAIL mid_reset got %h want 0", {sa_in_valid, sa_T, sa_in_data, sa_w_Q, sa_w_K, sa_w_V, busy}); end
        step();
    endtask

`ifdef SA_FEED_CHKSUM_EN
    task automatic test_chksum();
        run_feed(4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            sa_out_valid = 1'b1;
            sa_out_data = (i < 4) ? (64'd1 << i) : 64'd0;
            step();
        end
        sa_out_valid = 1'b0;
        tests++; if (done !== 1'b1 || chksum !== 64'hF) begin fails++; $display("FAIL chksum got done=%b sum=%h want 1/f", done, chksum); end
        step();
        tests++; if (chksum !== 64'hF) begin fails++; $display("FAIL chksum_hold got %h want f", chksum); end
    endtask
`endif

    initial begin
        step();
        test_reset();
        test_t1();
        test_illegal();
        test_t8();
        test_timeout();
        test_reset_mid();
`ifdef SA_FEED_CHKSUM_EN
        test_chksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
